fir_tap_ctrl: RTL and testbench
===============================

FIR_TAP_CTRL -- requirements
Module: fir_tap_ctrl

Interface
REQ-001 SHALL have parameter SIZE, default 8, sample width; coefficient width is SIZE+1.
REQ-002 SHALL have parameter LAT, default 3, filter datapath latency in CLK cycles (range 1..15).
REQ-003 CLK  in  1  single clock; all state changes on rising edge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 CFG_WE  in  1  write strobe for the shadow coefficient bank.
REQ-006 CFG_ADDR  in  2  shadow tap select (0..3 = C0..C3).
REQ-007 CFG_DATA  in  SIZE+1  coefficient value.
REQ-008 CFG_COMMIT  in  1  request to swap shadow bank into active bank.
REQ-009 CFG_BUSY  out  1  high while a commit is in progress; config inputs ignored.
REQ-010 IN_VALID  in  1  / IN_DATA  in  SIZE: upstream sample offer.
REQ-011 IN_READY  out  1  sample accepted on cycles with IN_VALID and IN_READY both high.
REQ-012 DATA  out  SIZE  registered sample driven to the filter datapath.
REQ-013 C0, C1, C2, C3  out  SIZE+1 each  registered active coefficients to the filter.
REQ-014 OUT_VALID  out  1  high exactly when the filter output is the result of an accepted sample.

Function
REQ-015 The filter SHALL advance one tap every CLK; DATA SHALL be IN_DATA (registered) after an accepted cycle, else 0 (zero bubble).
REQ-016 States SHALL be EMPTY, RUN, DRAIN, SWAP, FLUSH.
REQ-017 EMPTY: IN_READY=0, CFG_BUSY=0; CFG_COMMIT -> SWAP.
REQ-018 RUN: IN_READY=1, CFG_BUSY=0; CFG_COMMIT -> DRAIN.
REQ-019 DRAIN: IN_READY=0, CFG_BUSY=1; exits to SWAP the cycle after the valid pipeline (REQ-023) is all zero.
REQ-020 SWAP: one cycle; active C0..C3 <= shadow; CFG_BUSY=1, IN_READY=0; -> FLUSH.
REQ-021 FLUSH: exactly 3 cycles with DATA=0, IN_READY=0, CFG_BUSY=1 (clears the 4-tap delay line); -> RUN.
REQ-022 CFG_WE SHALL write shadow[CFG_ADDR] only when CFG_BUSY=0; writes while busy are dropped.
REQ-023 A LAT-deep shift register SHALL carry the accept flag; OUT_VALID = its last stage; OUT_VALID SHALL rise LAT cycles after the DATA register update for that sample.
REQ-024 CFG_WE and CFG_COMMIT in the same non-busy cycle: write SHALL land in shadow and be included in the swap.
REQ-025 IN_VALID and CFG_COMMIT same cycle in RUN: sample SHALL be accepted, then DRAIN; that sample's OUT_VALID SHALL appear before SWAP.
REQ-026 CFG_COMMIT while CFG_BUSY=1 SHALL be ignored (not queued).
REQ-027 Active coefficients SHALL never change in RUN, DRAIN or FLUSH; only in SWAP.
REQ-028 Every accepted sample SHALL be filtered with one coefficient set only (no mixed old/new taps).

Reset
REQ-029 RST_N low SHALL immediately force: state EMPTY, DATA=0, C0..C3=0, shadow bank=0, valid pipe=0, flush counter=0, OUT_VALID=0, IN_READY=0, CFG_BUSY=0.
REQ-030 Reset mid-DRAIN/FLUSH SHALL abort the commit; shadow and active contents are lost (zero).
REQ-031 Outputs SHALL leave reset values only on the first CLK edge after RST_N deasserts.

Verification (SIZE=8, LAT=3)
REQ-032 Reset then IN_VALID=1 with no commit -> IN_READY=0, DATA=0, OUT_VALID=0 indefinitely.
REQ-033 Write shadow 5,3,1,1 then commit from EMPTY -> CFG_BUSY=1 for 4 cycles (SWAP+3 FLUSH), C0..C3=5,3,1,1 from SWAP edge, IN_READY=1 after.
REQ-034 RUN, stream DATA 16,16,16 -> three OUT_VALID pulses, first 3 cycles after DATA=16 registers; no OUT_VALID on bubble cycles.
REQ-035 RUN with sample 13 accepted same cycle as commit with shadow C0=1 -> sample's OUT_VALID occurs in DRAIN while C0 still 5; C0=1 only after; DATA=0 for 3 FLUSH cycles.
REQ-036 CFG_WE addr 2 value 7 during FLUSH, and CFG_COMMIT during DRAIN -> shadow[2] unchanged, no second swap.
REQ-037 RST_N low during FLUSH -> all outputs zero asynchronously; EMPTY after release.

Source files
------------

// File: rtl/fir_tap_ctrl.sv
// Sample/coefficient front end for a 4-tap FIR: registers samples, holds the
// active coefficient bank and swaps in a shadow bank only once the datapath is idle.
module fir_tap_ctrl #(
  parameter int SIZE = 8,
  parameter int LAT  = 3
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_cfg_we,
  input  logic [1:0]      i_cfg_addr,
  input  logic [SIZE:0]   i_cfg_data,
  input  logic            i_cfg_commit,
  output logic            o_cfg_busy,
  input  logic            i_in_valid,
  input  logic [SIZE-1:0] i_in_data,
  output logic            o_in_ready,
  output logic [SIZE-1:0] o_data,
  output logic [SIZE:0]   o_c0,
  output logic [SIZE:0]   o_c1,
  output logic [SIZE:0]   o_c2,
  output logic [SIZE:0]   o_c3,
  output logic            o_out_valid
);

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_RUN,
    ST_DRAIN,
    ST_SWAP,
    ST_FLUSH
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_flush_cnt;
  logic [SIZE-1:0] r_data;
  logic            r_dvalid;
  logic [LAT-1:0]  r_vpipe;
  logic [SIZE:0]   r_shadow [4];
  logic [SIZE:0]   r_coef   [4];
  logic            w_accept;
  logic            w_pipe_empty;

  assign w_accept     = i_in_valid & o_in_ready;
  // r_dvalid travels with r_data, so it counts as part of the in-flight pipeline.
  assign w_pipe_empty = ~r_dvalid & ~(|r_vpipe);

  // NOTE: always_ff state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_EMPTY;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= (r_state == ST_FLUSH) ? r_flush_cnt + 2'd1 : 2'd0;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_cfg_busy  = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (i_cfg_commit) w_state_nxt = ST_SWAP;
      end
      ST_RUN: begin
        o_in_ready = 1'b1;
        if (i_cfg_commit) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        o_cfg_busy = 1'b1;
        if (w_pipe_empty) w_state_nxt = ST_SWAP;
      end
      ST_SWAP: begin
        o_cfg_busy  = 1'b1;
        w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        o_cfg_busy = 1'b1;
        if (r_flush_cnt == 2'd2) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Non-accepted cycles push a zero bubble into the tap delay line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data   <= '0;
      r_dvalid <= 1'b0;
      r_vpipe  <= '0;
    end else begin
      r_data   <= w_accept ? i_in_data : '0;
      r_dvalid <= w_accept;
      r_vpipe  <= LAT'({r_vpipe, r_dvalid});
    end
  end

  // NOTE: the coefficient banks are small register files that must read as
  // zero after reset, so they are reset explicitly rather than left as RAM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= '0;
        r_coef[i]   <= '0;
      end
    end else begin
      if (i_cfg_we && !o_cfg_busy) r_shadow[i_cfg_addr] <= i_cfg_data;
      if (r_state == ST_SWAP) begin
        for (int i = 0; i < 4; i++) r_coef[i] <= r_shadow[i];
      end
    end
  end

  assign o_data      = r_data;
  assign o_out_valid = r_vpipe[LAT-1];
  assign o_c0        = r_coef[0];
  assign o_c1        = r_coef[1];
  assign o_c2        = r_coef[2];
  assign o_c3        = r_coef[3];

endmodule

// File: tb/tb_fir_tap_ctrl.sv
// Directed bench for fir_tap_ctrl (SIZE=8, LAT=3): reset, commit from EMPTY,
// streaming, commit during traffic with drain, dropped busy writes, reset mid-flush.
module tb_fir_tap_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [8:0] cfg_data;
  logic       cfg_commit;
  logic       cfg_busy;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] data;
  logic [8:0] c0, c1, c2, c3;
  logic       out_valid;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  fir_tap_ctrl #(.SIZE(8), .LAT(3)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cfg_we     (cfg_we),
    .i_cfg_addr   (cfg_addr),
    .i_cfg_data   (cfg_data),
    .i_cfg_commit (cfg_commit),
    .o_cfg_busy   (cfg_busy),
    .i_in_valid   (in_valid),
    .i_in_data    (in_data),
    .o_in_ready   (in_ready),
    .o_data       (data),
    .o_c0         (c0),
    .o_c1         (c1),
    .o_c2         (c2),
    .o_c3         (c3),
    .o_out_valid  (out_valid)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_we     = 1'b0;
    cfg_addr   = 2'd0;
    cfg_data   = 9'd0;
    cfg_commit = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  32'(data), 0);
    check({tag, "_c0"},    32'(c0), 0);
    check({tag, "_c1"},    32'(c1), 0);
    check({tag, "_c2"},    32'(c2), 0);
    check({tag, "_c3"},    32'(c3), 0);
    check({tag, "_ov"},    32'(out_valid), 0);
    check({tag, "_ready"}, 32'(in_ready), 0);
    check({tag, "_busy"},  32'(cfg_busy), 0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_all_zero("rst");
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check_all_zero("rst_rel");

    // Sample offers in EMPTY are never accepted.
    in_valid = 1'b1;
    in_data  = 8'd55;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("empty_ready", 32'(in_ready), 0);
      check("empty_data",  32'(data), 0);
      check("empty_ov",    32'(out_valid), 0);
    end
    in_valid = 1'b0;

    // Load 5,3,1,1; last write shares the cycle with the commit.
    cfg_we = 1'b1;
    cfg_addr = 2'd0; cfg_data = 9'd5; tick();
    check("wr_busy0", 32'(cfg_busy), 0);
    cfg_addr = 2'd1; cfg_data = 9'd3; tick();
    cfg_addr = 2'd2; cfg_data = 9'd1; tick();
    cfg_addr = 2'd3; cfg_data = 9'd1; cfg_commit = 1'b1; tick();
    idle_inputs();
    check("swap_busy",  32'(cfg_busy), 1);
    check("swap_ready", 32'(in_ready), 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("flush_busy",  32'(cfg_busy), 1);
      check("flush_ready", 32'(in_ready), 0);
      check("flush_data",  32'(data), 0);
      check("flush_c0", 32'(c0), 5);
      check("flush_c1", 32'(c1), 3);
      check("flush_c2", 32'(c2), 1);
      check("flush_c3", 32'(c3), 1);
    end
    tick();
    check("run_busy",  32'(cfg_busy), 0);
    check("run_ready", 32'(in_ready), 1);

    // Three samples of 16, then bubbles; OUT_VALID trails DATA by 3 cycles.
    for (int i = 1; i <= 7; i++) begin
      in_valid = (i <= 3);
      in_data  = (i <= 3) ? 8'd16 : 8'd77;
      tick();
      check("stream_data", 32'(data), (i <= 3) ? 32'd16 : 32'd0);
      check("stream_ov",   32'(out_valid), (i >= 4 && i <= 6) ? 32'd1 : 32'd0);
    end
    idle_inputs();

    // Shadow C0=1 in RUN must not touch the active bank.
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 9'd1;
    tick();
    idle_inputs();
    check("shadow_wr_c0", 32'(c0), 5);
    check("shadow_wr_ready", 32'(in_ready), 1);

    // Sample 13 accepted with commit; extra commits in DRAIN and a write in FLUSH are dropped.
    for (int i = 1; i <= 10; i++) begin
      idle_inputs();
      in_valid = (i <= 9);
      in_data  = (i == 1) ? 8'd13 : 8'd99;
      if (i <= 3) cfg_commit = 1'b1;
      if (i == 8 || i == 9) begin
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 9'd7;
      end
      tick();
      check("drain_busy",  32'(cfg_busy), (i <= 9) ? 32'd1 : 32'd0);
      check("drain_ready", 32'(in_ready), (i == 10) ? 32'd1 : 32'd0);
      check("drain_ov",    32'(out_valid), (i == 4) ? 32'd1 : 32'd0);
      check("drain_data",  32'(data), (i == 1) ? 32'd13 : 32'd0);
      if (i != 6) check("drain_c0", 32'(c0), (i < 6) ? 32'd5 : 32'd1);
    end
    idle_inputs();
    tick();
    check("no_2nd_swap_busy", 32'(cfg_busy), 0);
    check("no_2nd_swap_ready", 32'(in_ready), 1);

    // Re-commit with no writes: C2 must still be 1, not the dropped 7.
    cfg_commit = 1'b1;
    tick();
    idle_inputs();
    check("recommit_busy", 32'(cfg_busy), 1);
    tick();
    tick();
    check("recommit_c0", 32'(c0), 1);
    check("recommit_c1", 32'(c1), 3);
    check("recommit_c2", 32'(c2), 1);
    check("recommit_c3", 32'(c3), 1);
    check("recommit_busy_flush", 32'(cfg_busy), 1);

    // Reset asserted mid-FLUSH clears everything without a clock edge.
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("flush_rst");
    #2;
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 32'(in_ready), 0);
    check("post_rst_busy",  32'(cfg_busy), 0);

    // Commit from EMPTY now swaps in the cleared shadow bank.
    cfg_commit = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();
    check("lost_c0", 32'(c0), 0);
    check("lost_c1", 32'(c1), 0);
    check("lost_ready", 32'(in_ready), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
